// File: rtl/kw11_pkg.sv
// Shared constants for the KW11-L line-time clock: CSR bit positions,
// default bus address / vector, and the mask of implemented CSR bits.
package kw11_pkg;
    localparam int          CSR_OVR      = 15;
    localparam int          CSR_MON      = 7;
    localparam int          CSR_IE       = 6;
    localparam logic [12:0] CSR_ADDR_DEF = 13'o17546;
    localparam logic [7:0]  VECTOR_DEF   = 8'o100;
    localparam logic [15:0] CSR_WMASK    = 16'o100300;
endpackage

// File: rtl/kw11_tick_gen.sv
// Single-cycle tick source: internal prescaler by default, or a synchronized
// rising-edge detector on line_i when KW11_EXT_LINE_EN is defined.
module kw11_tick_gen #(
    parameter int DIV_W = 20,
    parameter int DIV   = 833333
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic line_i,
    output logic tick_o
);
`ifdef KW11_EXT_LINE_EN
    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign tick_o = sync2_q & ~prev_q;
`else
    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             unused_line;

    assign unused_line = line_i;
    // The tick is asserted while the count sits at its terminal value.
    assign tick_o = (cnt_q == LAST);
    assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`endif
endmodule

// File: rtl/kw11_line_clock.sv
// KW11-L line-time clock: CSR (OVR/MON/IE), bus decode and interrupt request.
// Define KW11_EXT_LINE_EN to tick from line_in instead of the prescaler.
module kw11_line_clock
    import kw11_pkg::*;
#(
    parameter int          DIV_W    = 20,
    parameter int          DIV      = 833333,
    parameter logic [12:0] CSR_ADDR = CSR_ADDR_DEF,
    parameter logic [7:0]  VECTOR   = VECTOR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] iopage_addr,
    input  logic [15:0] data_in,
    input  logic        iopage_rd,
    input  logic        iopage_wr,
    input  logic        iopage_byte_op,
    input  logic        line_in,
    input  logic        interrupt_ack,
    output logic [15:0] data_out,
    output logic        decode,
    output logic        interrupt,
    output logic [7:0]  vector
);
    logic tick;
    logic ie_q, ie_d, mon_q, mon_d, ovr_q, ovr_d, req_q, req_d;
    logic wr_sel, even_wr, odd_wr;
    logic [15:0] csr;
    logic unused_bits;

    kw11_tick_gen #(.DIV_W(DIV_W), .DIV(DIV)) u_tick (
        .clk_i  (clk),
        .reset_i(reset),
        .line_i (line_in),
        .tick_o (tick)
    );

    assign unused_bits = ^{iopage_rd, data_in[14:8], data_in[5:0]};

    assign decode  = (iopage_addr[12:1] == CSR_ADDR[12:1]);
    assign wr_sel  = iopage_wr && decode;
    assign even_wr = wr_sel && (!iopage_byte_op || !iopage_addr[0]);
    assign odd_wr  = wr_sel && (!iopage_byte_op ||  iopage_addr[0]);

    always_comb begin
        csr          = '0;
        csr[CSR_OVR] = ovr_q;
        csr[CSR_MON] = mon_q;
        csr[CSR_IE]  = ie_q;
    end

    assign data_out  = decode ? (csr & CSR_WMASK) : 16'h0000;
    assign interrupt = req_q;
    assign vector    = VECTOR;

    // Ticks win over same-cycle clears; request decisions use the old IE.
    always_comb begin
        ie_d  = even_wr ? data_in[CSR_IE] : ie_q;

        mon_d = mon_q;
        if (even_wr && !data_in[CSR_MON]) mon_d = 1'b0;
        if (tick)                         mon_d = 1'b1;

        ovr_d = ovr_q;
        if (odd_wr && !data_in[CSR_OVR])                ovr_d = 1'b0;
        if (tick && ie_q && req_q && !interrupt_ack)    ovr_d = 1'b1;

        req_d = req_q;
        if (interrupt_ack || (wr_sel && !ie_d)) req_d = 1'b0;
        if (tick && ie_q)                       req_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ie_q  <= 1'b0;
            mon_q <= 1'b0;
            ovr_q <= 1'b0;
            req_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            mon_q <= mon_d;
            ovr_q <= ovr_d;
            req_q <= req_d;
        end
    end
endmodule

// File: tb/tb_kw11_line_clock.sv
// Directed bench for kw11_line_clock with DIV=4 (ticks every 4th posedge).
// Reads push the expected {vector, decode, interrupt, data_out}; a monitor pops and compares.
module tb_kw11_line_clock;
    localparam logic [12:0] ADDR_EVEN = 13'o17546;
    localparam logic [12:0] ADDR_ODD  = 13'o17547;
    localparam logic [12:0] ADDR_NONE = 13'o00000;
    localparam logic [7:0]  VEC       = 8'o100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] iopage_addr = '0;
    logic [15:0] data_in = '0;
    logic        iopage_rd = 1'b0;
    logic        iopage_wr = 1'b0;
    logic        iopage_byte_op = 1'b0;
    logic        line_in = 1'b0;
    logic        interrupt_ack = 1'b0;
    logic [15:0] data_out;
    logic        decode;
    logic        interrupt;
    logic [7:0]  vector;

    logic [25:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    kw11_line_clock #(.DIV_W(20), .DIV(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .iopage_addr   (iopage_addr),
        .data_in       (data_in),
        .iopage_rd     (iopage_rd),
        .iopage_wr     (iopage_wr),
        .iopage_byte_op(iopage_byte_op),
        .line_in       (line_in),
        .interrupt_ack (interrupt_ack),
        .data_out      (data_out),
        .decode        (decode),
        .interrupt     (interrupt),
        .vector        (vector)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // driver tasks
    task automatic read_check(input logic [12:0] a, input logic e_dec,
                              input logic e_int, input logic [15:0] e_data);
        exp_q.push_back({VEC, e_dec, e_int, e_data});
        iopage_addr = a;
        iopage_rd   = 1'b1;
        step();
        iopage_rd   = 1'b0;
    endtask

    task automatic write_csr(input logic [12:0] a, input logic bop, input logic [15:0] d);
        iopage_addr    = a;
        iopage_byte_op = bop;
        data_in        = d;
        iopage_wr      = 1'b1;
        step();
        iopage_wr      = 1'b0;
        iopage_byte_op = 1'b0;
        data_in        = '0;
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (iopage_rd) begin
            logic [25:0] act;
            logic [25:0] exp;
            act = {vector, decode, interrupt, data_out};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected: got %h, no expected entry", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL csr_read #%0d: got vec=%o dec=%b int=%b data=%o, want vec=%o dec=%b int=%b data=%o",
                             checks, act[25:18], act[17], act[16], act[15:0],
                             exp[25:18], exp[17], exp[16], exp[15:0]);
                end
            end
        end
    end

    // stimulus; t = posedges since reset release, reads observe state after edge t
    initial begin
        do_reset();
        read_check(ADDR_EVEN, 1, 0, 16'o000000);       // t0 reset state
        read_check(ADDR_NONE, 0, 0, 16'o000000);       // t1 undecoded
        step(); step();                                // t4 tick, IE=0
        read_check(ADDR_EVEN, 1, 0, 16'o000200);       // t4
        write_csr(ADDR_EVEN, 0, 16'o000100);           // t6 IE=1, MON cleared
        read_check(ADDR_EVEN, 1, 0, 16'o000100);       // t6
        step();                                        // t8 tick -> req
        read_check(ADDR_EVEN, 1, 1, 16'o000300);       // t8
        ack();                                         // t10
        read_check(ADDR_EVEN, 1, 0, 16'o000300);       // t10
        step();                                        // t12 tick -> req
        read_check(ADDR_ODD,  1, 1, 16'o000300);       // t12
        step(); step(); step();                        // t16 tick with req -> OVR
        read_check(ADDR_EVEN, 1, 1, 16'o100300);       // t16
        write_csr(ADDR_EVEN, 0, 16'o000100);           // t18 OVR, MON cleared
        read_check(ADDR_EVEN, 1, 1, 16'o000100);       // t18
        ack();                                         // t20 tick + ack
        read_check(ADDR_EVEN, 1, 1, 16'o000300);       // t20 no OVR
        ack();                                         // t22
        read_check(ADDR_EVEN, 1, 0, 16'o000300);       // t22
        write_csr(ADDR_EVEN, 0, 16'o000000);           // t24 tick + write 0
        read_check(ADDR_EVEN, 1, 1, 16'o000200);       // t24 old IE raised req
        write_csr(ADDR_EVEN, 0, 16'o000000);           // t26 req dropped
        read_check(ADDR_EVEN, 1, 0, 16'o000000);       // t26
        write_csr(ADDR_EVEN, 0, 16'o000100);           // t28 tick + IE write
        read_check(ADDR_EVEN, 1, 0, 16'o000300);       // t28 no req from old IE=0
        step(); step();                                // t31
        step();                                        // t32 tick -> req
        read_check(ADDR_EVEN, 1, 1, 16'o000300);       // t32
        step(); step(); step();                        // t36 OVR
        read_check(ADDR_EVEN, 1, 1, 16'o100300);       // t36
        write_csr(ADDR_ODD, 1, 16'o000000);            // t38 odd byte: OVR only
        read_check(ADDR_EVEN, 1, 1, 16'o000300);       // t38
        step();                                        // t40 OVR again
        read_check(ADDR_EVEN, 1, 1, 16'o100300);       // t40
        write_csr(ADDR_EVEN, 1, 16'o000100);           // t42 even byte: OVR kept
        read_check(ADDR_EVEN, 1, 1, 16'o100100);       // t42
        write_csr(ADDR_EVEN, 1, 16'o000000);           // t44 tick, old IE=1, req held
        read_check(ADDR_EVEN, 1, 1, 16'o100200);       // t44
        write_csr(ADDR_EVEN, 0, 16'o000000);           // t46 all cleared
        read_check(ADDR_EVEN, 1, 0, 16'o000000);       // t46
        step(); step();                                // t48 tick, t49
        write_csr(ADDR_EVEN, 0, 16'o000100);           // t50 IE=1, MON cleared
        read_check(ADDR_EVEN, 1, 0, 16'o000100);       // t50
        step();                                        // t52 tick -> req
        read_check(ADDR_EVEN, 1, 1, 16'o000300);       // t52
        do_reset();                                    // mid-period reset
        read_check(ADDR_EVEN, 1, 0, 16'o000000);       // t0
        step(); step();                                // t3
        read_check(ADDR_EVEN, 1, 0, 16'o000000);       // t3 prescaler restarted
        read_check(ADDR_EVEN, 1, 0, 16'o000200);       // t4 tick
        write_csr(ADDR_NONE, 0, 16'o000100);           // t6 undecoded write ignored
        read_check(ADDR_EVEN, 1, 0, 16'o000200);       // t6
        step();                                        // t8 tick, IE=0
        read_check(ADDR_EVEN, 1, 0, 16'o000200);       // t8
        step(); step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
